// File: rtl/ctu_pkg.sv
// Shared constants and helpers for the cascaded tick generator.
//   DEF_LIMIT_100M / DEF_LIMIT_50M : stage-0 limits for a 1 s tick at 100 / 50 MHz
//   DEF_SEC_LIMIT_1S / _2S         : stage-1 limits giving a pulse every 1 / 2 stage-0 wraps
//   limit_fits()                   : true when a limit value is representable in a given width
package ctu_pkg;

  localparam longint unsigned DEF_LIMIT_100M   = 64'd99_999_999;
  localparam longint unsigned DEF_LIMIT_50M    = 64'd49_999_999;
  localparam longint unsigned DEF_SEC_LIMIT_1S = 64'd0;
  localparam longint unsigned DEF_SEC_LIMIT_2S = 64'd1;

  function automatic logic limit_fits(input longint unsigned lim, input int unsigned w);
    if (w >= 64) begin
      return 1'b1;
    end
    return lim < (64'd1 << w);
  endfunction

endpackage

// File: rtl/ctu_cascade_if.sv
// Control/status bundle of the cascaded tick generator.
//   enable_i, count_up_i : advance qualifiers (advance = both high)
//   clear_i, load_i      : synchronous clear / limit load, clear wins
//   limit_i, sec_limit_i : limits sampled on load_i
//   ack_i                : acknowledges the sticky stage-1 flag
//   data_o, sec_cnt_o    : stage counts
//   overflow_o, overflow_sec_o, ovf_sticky_o : wrap pulses and sticky flag
// master = the controlling side, slave = the counter block.
interface ctu_cascade_if #(
  parameter int unsigned CNT_W = 27,
  parameter int unsigned SEC_W = 4
);
  logic             enable_i;
  logic             count_up_i;
  logic             clear_i;
  logic             load_i;
  logic [CNT_W-1:0] limit_i;
  logic [SEC_W-1:0] sec_limit_i;
  logic             ack_i;
  logic [CNT_W-1:0] data_o;
  logic [SEC_W-1:0] sec_cnt_o;
  logic             overflow_o;
  logic             overflow_sec_o;
  logic             ovf_sticky_o;

  modport master (
    output enable_i, count_up_i, clear_i, load_i, limit_i, sec_limit_i, ack_i,
    input  data_o, sec_cnt_o, overflow_o, overflow_sec_o, ovf_sticky_o
  );

  modport slave (
    input  enable_i, count_up_i, clear_i, load_i, limit_i, sec_limit_i, ack_i,
    output data_o, sec_cnt_o, overflow_o, overflow_sec_o, ovf_sticky_o
  );

endinterface

// File: rtl/ctu_stage.sv
// Generic wrap counter with a loadable limit.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   adv_i        : advance request
//   clr_i        : zero the count, keep the limit (beats ld_i)
//   ld_i, lim_i  : take a new limit and zero the count
//   cnt_o        : current count, never above the limit
//   wrap_o       : combinational, high when this edge wraps the counter
//   pulse_o      : registered one-cycle wrap pulse
module ctu_stage #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0] DEF = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         pulse_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] limit_q, limit_d;
  logic         pulse_q, pulse_d;
  logic         at_lim;

  assign at_lim = (cnt_q == limit_q);
  // Qualified by clear/load so the next stage and the sticky flag never see a
  // wrap on an edge where the counter is actually being cleared or reloaded.
  assign wrap_o = adv_i & ~clr_i & ~ld_i & at_lim;

  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    pulse_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      limit_d = lim_i;
      cnt_d   = '0;
    end else if (adv_i) begin
      if (at_lim) begin
        cnt_d   = '0;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      limit_q <= DEF;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      pulse_q <= pulse_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/ctu_cascade.sv
// Two-stage cascaded divider / tick generator.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : control/status bundle (slave side)
// Stage 0 divides qualified advances by limit+1; stage 1 counts stage-0 wraps
// and pulses in the same cycle as the stage-0 pulse that completes its period.
// ovf_sticky_o latches stage-1 wraps until acknowledged; a wrap beats an ack.
module ctu_cascade
  import ctu_pkg::*;
#(
  parameter int unsigned     CNT_W         = 27,
  parameter longint unsigned DEF_LIMIT     = DEF_LIMIT_100M,
  parameter int unsigned     SEC_W         = 4,
  parameter longint unsigned DEF_SEC_LIMIT = DEF_SEC_LIMIT_2S
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ctu_cascade_if.slave bus
);

  if (!limit_fits(DEF_LIMIT, CNT_W)) begin : g_bad_def_limit
    $error("DEF_LIMIT does not fit in CNT_W bits");
  end
  if (!limit_fits(DEF_SEC_LIMIT, SEC_W)) begin : g_bad_def_sec_limit
    $error("DEF_SEC_LIMIT does not fit in SEC_W bits");
  end

  logic adv;
  logic wrap0;
  logic wrap1;
  logic sticky_q, sticky_d;

  assign adv = bus.enable_i & bus.count_up_i;

  ctu_stage #(
    .W   (CNT_W),
    .DEF (CNT_W'(DEF_LIMIT))
  ) u_stage0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .adv_i   (adv),
    .clr_i   (bus.clear_i),
    .ld_i    (bus.load_i),
    .lim_i   (bus.limit_i),
    .cnt_o   (bus.data_o),
    .wrap_o  (wrap0),
    .pulse_o (bus.overflow_o)
  );

  ctu_stage #(
    .W   (SEC_W),
    .DEF (SEC_W'(DEF_SEC_LIMIT))
  ) u_stage1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .adv_i   (wrap0),
    .clr_i   (bus.clear_i),
    .ld_i    (bus.load_i),
    .lim_i   (bus.sec_limit_i),
    .cnt_o   (bus.sec_cnt_o),
    .wrap_o  (wrap1),
    .pulse_o (bus.overflow_sec_o)
  );

  always_comb begin
    sticky_d = sticky_q;
    if (wrap1) begin
      sticky_d = 1'b1;
    end else if (bus.ack_i) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_ctu_cascade.sv
// Directed bench for ctu_cascade with CNT_W=4, DEF_LIMIT=9, SEC_W=2, DEF_SEC_LIMIT=1.
module tb_ctu_cascade;

  localparam int unsigned CW = 4;
  localparam int unsigned SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ctu_cascade_if #(.CNT_W(CW), .SEC_W(SW)) bus ();

  ctu_cascade #(
    .CNT_W         (CW),
    .DEF_LIMIT     (9),
    .SEC_W         (SW),
    .DEF_SEC_LIMIT (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int d, input int s, input int o,
                           input int os, input int st);
    check({tag, ".data"},   32'(bus.data_o),         32'(d));
    check({tag, ".sec"},    32'(bus.sec_cnt_o),      32'(s));
    check({tag, ".ovf"},    32'(bus.overflow_o),     32'(o));
    check({tag, ".ovfsec"}, 32'(bus.overflow_sec_o), 32'(os));
    check({tag, ".sticky"}, 32'(bus.ovf_sticky_o),   32'(st));
  endtask

  // One rising edge, then sample 1 time unit later; inputs change after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.enable_i    = 1'b0;
    bus.count_up_i  = 1'b0;
    bus.clear_i     = 1'b0;
    bus.load_i      = 1'b0;
    bus.limit_i     = '0;
    bus.sec_limit_i = '0;
    bus.ack_i       = 1'b0;

    // Reset state
    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    check_all("idle", 0, 0, 0, 0, 0);

    // 25 advances at the default limits 9/1
    bus.enable_i   = 1'b1;
    bus.count_up_i = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      check("run.data", 32'(bus.data_o), 32'(c % 10));
      check("run.ovf", 32'(bus.overflow_o), 32'(c == 10 || c == 20));
      check("run.sec", 32'(bus.sec_cnt_o), 32'((c >= 10 && c < 20) ? 1 : 0));
      check("run.ovfsec", 32'(bus.overflow_sec_o), 32'(c == 20));
      check("run.sticky", 32'(bus.ovf_sticky_o), 32'(c >= 20));
    end

    // Enable low for 3 cycles at data=5
    bus.enable_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("hold", 5, 0, 0, 0, 1);
    end
    bus.enable_i = 1'b1;
    step();
    check_all("resume", 6, 0, 0, 0, 1);
    step();
    check("to7", 32'(bus.data_o), 32'd7);

    // Load 3/0 at data=7, advance still high (load wins)
    bus.load_i      = 1'b1;
    bus.limit_i     = 4'd3;
    bus.sec_limit_i = 2'd0;
    step();
    check_all("load", 0, 0, 0, 0, 1);
    bus.load_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check("l3.data", 32'(bus.data_o), 32'(c % 4));
      check("l3.ovf", 32'(bus.overflow_o), 32'(c % 4 == 0));
      check("l3.ovfsec", 32'(bus.overflow_sec_o), 32'(c % 4 == 0));
      check("l3.sec", 32'(bus.sec_cnt_o), 32'd0);
    end

    // Back to 9/1, count to 9, then clear+load together (clear wins)
    bus.load_i      = 1'b1;
    bus.limit_i     = 4'd9;
    bus.sec_limit_i = 2'd1;
    step();
    bus.load_i = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check("at9", 32'(bus.data_o), 32'd9);
    bus.clear_i     = 1'b1;
    bus.load_i      = 1'b1;
    bus.limit_i     = 4'd3;
    bus.sec_limit_i = 2'd0;
    step();
    check_all("clrld", 0, 0, 0, 0, 1);
    bus.clear_i = 1'b0;
    bus.load_i  = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check_all("keep9", 9, 0, 0, 0, 1);
    step();
    // Limit 9 and sec limit 1 retained: wrap here, sec goes to 1, no sec pulse
    check_all("keepwrap", 0, 1, 1, 0, 1);

    // Ack alone clears the sticky flag
    bus.enable_i = 1'b0;
    bus.ack_i    = 1'b1;
    step();
    check_all("ack", 0, 1, 0, 0, 0);
    bus.ack_i    = 1'b0;
    bus.enable_i = 1'b1;
    for (int c = 0; c < 9; c++) step();
    check_all("pre", 9, 1, 0, 0, 0);
    // Ack coincident with a stage-1 wrap: set wins
    bus.ack_i = 1'b1;
    step();
    check_all("ackwrap", 0, 0, 1, 1, 1);
    bus.enable_i = 1'b0;
    step();
    check_all("ack2", 0, 0, 0, 0, 0);
    bus.ack_i = 1'b0;

    // Change limits to 15/3, count to 6, then async reset mid-cycle
    bus.load_i      = 1'b1;
    bus.limit_i     = 4'd15;
    bus.sec_limit_i = 2'd3;
    step();
    bus.load_i   = 1'b0;
    bus.enable_i = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("at6", 32'(bus.data_o), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    bus.enable_i = 1'b0;
    #4;
    rst_n = 1'b1;
    step();
    check_all("post_rst", 0, 0, 0, 0, 0);

    // Limits must be back to 9/1
    bus.enable_i = 1'b1;
    for (int c = 0; c < 9; c++) step();
    check_all("r9", 9, 0, 0, 0, 0);
    step();
    check_all("r10", 0, 1, 1, 0, 0);
    for (int c = 0; c < 10; c++) step();
    check_all("r20", 0, 0, 1, 1, 1);
    bus.enable_i = 1'b0;
    step();
    check_all("r21", 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctu_cascade.md
Name: ctu_cascade

Overview:
- Parametrised two-stage cascaded frequency divider / tick generator for the button-driver and divider subsystem.
- Stage 0 divides qualified clock advances by a runtime-loadable limit and emits a one-cycle wrap pulse.
- Stage 1 counts stage-0 wraps against a second loadable limit and emits a coincident long-period pulse (e.g. 1 s / 2 s ticks), plus a sticky flag that software acknowledges.

Parameters:
- CNT_W, 27, width of the stage-0 counter and its limit.
- DEF_LIMIT, 27'h5F5E0FF (10^8-1), stage-0 limit after reset; must fit in CNT_W.
- SEC_W, 4, width of the stage-1 counter and its limit.
- DEF_SEC_LIMIT, 1, stage-1 limit after reset (pulse every DEF_SEC_LIMIT+1 stage-0 wraps).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  global enable; low freezes both stages.
- count_up_i  in  1  advance qualifier; advance = enable_i & count_up_i.
- clear_i  in  1  synchronous clear of both counters; limits kept.
- load_i  in  1  synchronous load of limit_i/sec_limit_i; zeroes both counters.
- limit_i  in  CNT_W  new stage-0 limit, sampled when load_i=1.
- sec_limit_i  in  SEC_W  new stage-1 limit, sampled when load_i=1.
- ack_i  in  1  clears ovf_sticky_o.
- data_o  out  CNT_W  stage-0 count.
- sec_cnt_o  out  SEC_W  stage-1 count.
- overflow_o  out  1  one-cycle stage-0 wrap pulse.
- overflow_sec_o  out  1  one-cycle stage-1 wrap pulse.
- ovf_sticky_o  out  1  set by a stage-1 wrap, held until ack_i.

Behaviour:
- Reset (rst_i=0, asynchronous): data_o=0, sec_cnt_o=0, overflow_o=0, overflow_sec_o=0, ovf_sticky_o=0, limit_q=DEF_LIMIT, sec_limit_q=DEF_SEC_LIMIT. Reset mid-count aborts immediately; no pulse is emitted on release.
- Per-edge priority: clear_i > load_i > advance > hold.
- clear_i=1: both counters go to 0 and both pulses to 0 on that edge. Limits are unchanged and ovf_sticky_o is unaffected.
- load_i=1 (clear_i=0): limit_q<=limit_i and sec_limit_q<=sec_limit_i. Both counters go to 0 and pulses to 0. The new limits govern from the next advance.
- Advance, stage 0:
  - data_o==limit_q: data_o<=0 and overflow_o<=1 on the same edge.
  - Otherwise: data_o<=data_o+1 and overflow_o<=0.
  - limit_q=0 gives a pulse on every advance.
- Stage 1 advances only on a stage-0 wrap edge (wrap0 = advance & data_o==limit_q):
  - sec_cnt_o==sec_limit_q: sec_cnt_o<=0 and overflow_sec_o<=1, coincident with that overflow_o pulse.
  - Otherwise: sec_cnt_o+1 and overflow_sec_o<=0.
- No advance (enable_i=0 or count_up_i=0): counters hold; both pulses 0 on the next edge.
- Pulses are registered and high for exactly one cycle per wrap. Back-to-back wraps (limit 0) hold the pulse high on consecutive cycles.
- ovf_sticky_o: set on any edge where the stage-1 wrap occurs. Cleared on an edge where ack_i=1 and no stage-1 wrap occurs; simultaneous set and ack leaves it set.
- Counters never exceed their limits, because load always zeroes them. Arithmetic is unsigned and width-exact, with no carry beyond CNT_W/SEC_W.

Decomposition:
- Package ctu_pkg: DEF_LIMIT_100M (10^8-1), DEF_LIMIT_50M, default SEC limits, and a function checking that a limit fits in its width.
- One natural sub-module, ctu_stage #(W): generic wrap counter.
  - Inputs: adv, clr, ld, lim.
  - Outputs: cnt, combinational wrap_o, registered pulse_o.
  - Instantiated twice; stage-1 adv = stage-0 wrap_o.

Test Plan (CNT_W=4, DEF_LIMIT=9, SEC_W=2, DEF_SEC_LIMIT=1):
- Reset, then enable_i=count_up_i=1 for 25 cycles -> data_o counts 0..9 and wraps; overflow_o high in cycles 10 and 20 only; overflow_sec_o and ovf_sticky_o rise in cycle 20 only.
- Drop enable_i for 3 cycles at data_o=5 -> data_o holds 5, pulses stay 0; counting resumes to 6 after re-enable.
- load_i with limit_i=3, sec_limit_i=0 at data_o=7 -> counters 0; overflow_o every 4th advance; overflow_sec_o coincident with every overflow_o.
- clear_i and load_i asserted on the edge where data_o=9 -> counters 0, no overflow_o, limits unchanged.
- ack_i asserted on the same edge as a stage-1 wrap -> ovf_sticky_o stays 1; ack_i next cycle -> 0.
- rst_i pulsed low asynchronously mid-cycle at data_o=6 -> all outputs 0 immediately, limits back to 9/1, no pulse after release.
